uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Oversampling UART receiver.
- Converts the asynchronous serial line rx_uart into parallel bytes with per-byte error flags.
- Timed entirely by the 16x-baud clk_enable pulse from the controller's baud divider.
- Output feeds the rx-side AXI-stream FIFO write port:
  - rx_data → tdata
  - !rx_data_error → tkeep
  - rx_data_valid → tvalid

Parameters:
- DATA_BITS, 8: payload bits per frame, LSB first.
- OVERSAMPLE, 16: clk_enable ticks per bit period; even, ≥8.
- SYNC_STAGES, 2: metastability flops on rx_uart; ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_enable  in  1  one-clk-wide pulse at OVERSAMPLE×baud
- parity_en  in  1  1 = expect even-parity bit after data
- rx_uart  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  received payload
- rx_data_valid  out  1  one-cycle strobe, frame complete
- rx_data_error  out  1  parity_error | framing_error, qualified by rx_data_valid
- parity_error  out  1  parity mismatch, qualified by rx_data_valid
- framing_error  out  1  stop bit sampled low, qualified by rx_data_valid

Behaviour:
- Reset values:
  - all outputs 0
  - synchronizer flops 1
  - state IDLE
  - tick counter 0
- Synchronizer: rx_uart passes through SYNC_STAGES flops on every clk, not gated by clk_enable. All sampling uses the last stage (rx_s).
- All state, counter and sample updates occur only on cycles with clk_enable=1, except that rx_data_valid is cleared every cycle.
- Tick counter: width $clog2(OVERSAMPLE); cleared on every state transition.
- Sample decision point: bit value = rx_s at the tick where the counter reaches the decision point.
  - Start bit: decision point OVERSAMPLE/2-1.
  - Data, parity and stop bits: decision point OVERSAMPLE-1.
- States:
  - IDLE: on a tick with rx_s=0, go to START (counter 0).
  - START: at counter OVERSAMPLE/2-1:
    - sample 1 (glitch) → IDLE, nothing emitted.
    - sample 0 → DATA; latch parity_en into a frame-local bit; clear the bit index.
  - DATA:
    - At each OVERSAMPLE-1, shift the sample into bit[index], LSB first, then increment index.
    - After index DATA_BITS-1 → PARITY if latched parity_en, else STOP.
  - PARITY: at OVERSAMPLE-1, compute parity_error = XOR(data bits, sample) (even parity), then → STOP.
  - STOP: at OVERSAMPLE-1:
    - Load rx_data, parity_error and framing_error = ~sample.
    - Pulse rx_data_valid on the next clk edge, for exactly 1 clk.
    - Next state is IDLE if the sample is 1, else WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rx_s=1, then → IDLE. This prevents re-triggering on a break condition.
- Back-to-back frames: STOP returns to IDLE at mid-stop-bit, so a start edge immediately following the stop bit is detected.
- parity_en changes mid-frame have no effect until the next start confirmation.
- rx_data holds its value between strobes. The error outputs hold their last values but are meaningful only with rx_data_valid.
- Reset mid-frame: immediate return to IDLE with all outputs cleared. The partial frame is discarded with no strobe.
- No backpressure: a strobe is produced regardless of downstream state.

Optional Feature:
- Macro UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit value is the 2-of-3 majority of rx_s at counter values D-2, D-1 and D, where D is the decision point.
  - Decision time is unchanged.
  - Start-glitch rejection uses the same vote.
- Undefined: single sample at D, and the vote flops are not instantiated.

Decomposition:
- Package uart_pkg holds:
  - typedef enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}
  - localparam UART_OVERSAMPLE_DEFAULT = 16
  - function even_parity()
- One sub-module, uart_rx_sampler:
  - contains the synchronizer plus the optional majority-vote window
  - outputs rx_s and the voted bit

Test Plan:
- OVERSAMPLE=16, parity off, send 0xA5 with 1 stop bit → single rx_data_valid pulse; rx_data=0xA5; all error flags 0; strobe 1 clk after the stop-bit decision tick.
- Parity on, send 0x3C:
  - parity bit 0 → rx_data=0x3C, parity_error=0.
  - parity bit 1 → parity_error=1, rx_data_error=1.
- Drive rx_uart low for 4 ticks then high → no strobe; FSM back in IDLE; a following 0x55 frame is received correctly.
- Send 0x81 with the stop bit low, then hold the line low for 40 ticks → one strobe with rx_data=0x81 and framing_error=1; no further strobes until the line returns high; the next frame 0x42 is received cleanly.
- Back-to-back 0x00 then 0xFF with no idle gap → two strobes, data 0x00 then 0xFF, no errors.
- Assert reset during data bit 4, then release and send 0x7E → no strobe for the aborted frame; outputs 0 during reset; next strobe rx_data=0x7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  // Widest payload the parity helper accepts; narrower payloads are zero-extended.
  localparam int UART_MAX_DATA_BITS = 16;

  // Even parity of a zero-extended payload: 1 when the number of ones is odd.
  function automatic logic even_parity(input logic [UART_MAX_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: metastability synchronizer on
// rx_uart plus, when UART_RX_MAJORITY_VOTE_EN is defined, a 2-of-3 vote over
// the last three clk_enable ticks. rx_s is the synchronized line; rx_bit is the
// value the receiver uses at a decision point.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  input  logic rx_uart,
  output logic rx_s,
  output logic rx_bit
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw line into the synchronizer chain every clk.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_uart};
  end

  // Synchronizer flops reset to the idle-high line level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  // hist_q[0] holds rx_s from the previous tick (D-1), hist_q[1] from two ticks ago (D-2).
  logic [1:0] hist_q;
  logic [1:0] hist_d;

  // Advance the vote history on each oversample tick.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hist_d = hist_q;
    if (clk_enable) hist_d = {hist_q[0], rx_s};
  end

  // Vote history register.
  always_ff @(posedge clk) begin
    if (reset) hist_q <= '1;
    else       hist_q <= hist_d;
  end

  assign rx_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  logic unused_clk_enable;
  assign unused_clk_enable = clk_enable;
  assign rx_bit            = rx_s;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: turns the asynchronous rx_uart line into bytes
// with per-frame parity/framing error flags, timed by the OVERSAMPLE x baud
// clk_enable pulse. Optional build macro: UART_RX_MAJORITY_VOTE_EN selects a
// 2-of-3 vote around each decision point (see uart_rx_sampler).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 parity_en,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_data_error,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Start bit is judged half a bit in; every later bit a full bit after the previous decision.
  localparam logic [CNT_W-1:0] START_POINT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_POINT   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic rx_bit;

  uart_rx_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .rx_uart   (rx_uart),
    .rx_s      (rx_s),
    .rx_bit    (rx_bit)
  );

  uart_rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_en_q, par_en_d;
  logic                   perr_frame_q, perr_frame_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   parity_error_q, parity_error_d;
  logic                   framing_error_q, framing_error_d;
  logic                   valid_q, valid_d;
  logic [UART_MAX_DATA_BITS-1:0] data_ext;

  // Frame FSM: next state, bit assembly and output loading, all advanced only on ticks.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shreg_d         = shreg_q;
    par_en_d        = par_en_q;
    perr_frame_d    = perr_frame_q;
    rx_data_d       = rx_data_q;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    valid_d         = 1'b0;

    data_ext                 = '0;
    data_ext[DATA_BITS-1:0]  = shreg_q;

    if (clk_enable) begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!rx_s) state_d = START;
        end
        START: begin
          if (cnt_q == START_POINT) begin
            cnt_d = '0;
            if (rx_bit) begin
              state_d = IDLE;
            end else begin
              state_d      = DATA;
              par_en_d     = parity_en;
              idx_d        = '0;
              perr_frame_d = 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt_q == BIT_POINT) begin
            cnt_d          = '0;
            shreg_d[idx_q] = rx_bit;
            if (idx_q == LAST_IDX) state_d = par_en_q ? PARITY : STOP;
            else                   idx_d   = idx_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == BIT_POINT) begin
            cnt_d        = '0;
            perr_frame_d = even_parity(data_ext) ^ rx_bit;
            state_d      = STOP;
          end
        end
        STOP: begin
          if (cnt_q == BIT_POINT) begin
            cnt_d           = '0;
            rx_data_d       = shreg_q;
            parity_error_d  = perr_frame_q;
            framing_error_d = ~rx_bit;
            valid_d         = 1'b1;
            state_d         = rx_bit ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          cnt_d = '0;
          if (rx_s) state_d = IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter, assembly and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shreg_q         <= '0;
      par_en_q        <= 1'b0;
      perr_frame_q    <= 1'b0;
      rx_data_q       <= '0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      valid_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shreg_q         <= shreg_d;
      par_en_q        <= par_en_d;
      perr_frame_q    <= perr_frame_d;
      rx_data_q       <= rx_data_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      valid_q         <= valid_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign rx_data_error = parity_error_q | framing_error_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a frame-level model predicts each
// strobe (payload, error flags, and the tick at the centre of the stop bit);
// a compare process checks every strobe against it, and literal checks pin
// the model on a few hand-computed cases.
module tb_uart_rx_core;

  localparam int OVS  = 16;
  localparam int DB   = 8;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_enable;
  logic          parity_en;
  logic          rx_uart;
  logic [DB-1:0] rx_data;
  logic          rx_data_valid;
  logic          rx_data_error;
  logic          parity_error;
  logic          framing_error;

  uart_rx_core #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OVS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .parity_en    (parity_en),
    .rx_uart      (rx_uart),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_error(rx_data_error),
    .parity_error (parity_error),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
    int            stop_tick;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int tick_count = 0;
  logic last_edge_tick = 1'b0;
  int last_strobe_tick = -1;
  int n_strobes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // clk_enable: one-clk pulse every 4 clks.
  initial begin
    int div;
    div = 0;
    clk_enable = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == 3) ? 0 : div + 1;
      clk_enable = (div == 0);
    end
  end

  // Tick bookkeeping for the frame model.
  always @(posedge clk) begin
    last_edge_tick = clk_enable;
    if (clk_enable) tick_count++;
  end

  // Compare process: every strobe must match the oldest predicted frame.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rx_data_valid) begin
      n_strobes++;
      last_strobe_tick = tick_count;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_data", rx_data, e.data);
        check("strobe_parity_error", parity_error, e.perr);
        check("strobe_framing_error", framing_error, e.ferr);
        check("strobe_rx_data_error", rx_data_error, e.perr | e.ferr);
        check("strobe_tick", tick_count, e.stop_tick);
        check("strobe_after_tick_edge", last_edge_tick, 1'b1);
      end
    end
  end

  // Return just after the n-th upcoming clk_enable tick has been clocked.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (clk_enable !== 1'b1);
    end
    #1;
  endtask

  task automatic drive_level(input logic lvl, input int n);
    rx_uart = lvl;
    wait_ticks(n);
  endtask

  // Drive one frame and predict its strobe: the stop decision lands at the
  // centre of the stop bit, counted from the tick the start edge is first seen.
  task automatic send_frame(input logic [DB-1:0] data, input bit use_par,
                            input logic par_bit, input logic stop_lvl);
    exp_t e;
    int   stop_idx;
    parity_en   = use_par;
    e.data      = data;
    e.perr      = use_par ? ((^data) ^ par_bit) : 1'b0;
    e.ferr      = ~stop_lvl;
    stop_idx    = 1 + DB + (use_par ? 1 : 0);
    e.stop_tick = tick_count + 1 + stop_idx * OVS + OVS / 2;
    exp_q.push_back(e);
    drive_level(1'b0, OVS);
    for (int i = 0; i < DB; i++) drive_level(data[i], OVS);
    if (use_par) drive_level(par_bit, OVS);
    drive_level(stop_lvl, OVS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int t_first;
    int s0;

    reset     = 1'b1;
    parity_en = 1'b0;
    rx_uart   = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_valid", rx_data_valid, 1'b0);
    check("reset_parity_error", parity_error, 1'b0);
    check("reset_framing_error", framing_error, 1'b0);
    check("reset_rx_data_error", rx_data_error, 1'b0);
    reset = 1'b0;
    wait_ticks(4);

    // 0xA5, no parity: strobe 152 ticks after the start edge is first seen.
    t_first = tick_count + 1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_strobe_offset", last_strobe_tick - t_first, 32'd152);
    check("a5_data_held", rx_data, 8'hA5);
    check("a5_error_held", rx_data_error, 1'b0);
    drive_level(1'b1, 8);

    // 0x3C with even parity: correct bit, then wrong bit.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    check("3c_p0_parity_error", parity_error, 1'b0);
    check("3c_p0_data", rx_data, 8'h3C);
    drive_level(1'b1, 8);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check("3c_p1_parity_error", parity_error, 1'b1);
    check("3c_p1_rx_data_error", rx_data_error, 1'b1);
    parity_en = 1'b0;
    drive_level(1'b1, 8);

    // Start glitch of 4 ticks: rejected, then a clean frame.
    s0 = n_strobes;
    drive_level(1'b0, 4);
    drive_level(1'b1, 20);
    check("glitch_no_strobe", n_strobes - s0, 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    check("55_data", rx_data, 8'h55);
    drive_level(1'b1, 8);

    // Framing error followed by a 40-tick break.
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    s0 = n_strobes;
    drive_level(1'b0, 40);
    check("break_no_extra_strobe", n_strobes - s0, 32'd0);
    check("81_framing_error", framing_error, 1'b1);
    check("81_data", rx_data, 8'h81);
    drive_level(1'b1, 20);
    send_frame(8'h42, 1'b0, 1'b0, 1'b1);
    check("42_framing_error", framing_error, 1'b0);
    drive_level(1'b1, 8);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    check("ff_data", rx_data, 8'hFF);
    drive_level(1'b1, 8);

    // Reset in the middle of data bit 4 of a 0x0F frame.
    s0 = n_strobes;
    drive_level(1'b0, OVS);
    for (int i = 0; i < 4; i++) drive_level(1'b1, OVS);
    drive_level(1'b0, OVS / 2);
    @(negedge clk);
    reset   = 1'b1;
    rx_uart = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_valid", rx_data_valid, 1'b0);
    check("midreset_rx_data_error", rx_data_error, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(24);
    check("aborted_frame_no_strobe", n_strobes - s0, 32'd0);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    check("7e_data", rx_data, 8'h7E);
    drive_level(1'b1, 8);

    check("pending_strobes", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
